// File: rtl/mat_row_writer_if.sv
// Row-in / memory-write-out bus for the matrix row writer.
// master = op unit plus memory side, slave = mat_row_writer.
interface mat_row_writer_if #(
  parameter int COLS   = 5,
  parameter int ELEM_W = 8,
  parameter int ADDR_W = 8
);
  logic [COLS*ELEM_W-1:0] in_row;
  logic                   in_ovf;
  logic                   in_valid;
  logic                   in_ready;
  logic                   mem_wr_en;
  logic [ADDR_W-1:0]      mem_addr;
  logic [ELEM_W-1:0]      mem_wr_data;
  logic                   mem_ready;

  modport master (
    output in_row, in_ovf, in_valid, mem_ready,
    input  in_ready, mem_wr_en, mem_addr, mem_wr_data
  );

  modport slave (
    input  in_row, in_ovf, in_valid, mem_ready,
    output in_ready, mem_wr_en, mem_addr, mem_wr_data
  );
endinterface

// File: rtl/mat_row_writer.sv
// Drain side of the matrix ALU row path: serialises ROWS packed rows into element writes.
// Optional MAT_WR_SAT_EN: rows flagged with overflow have 8'h80-style elements written as max positive.
module mat_row_writer #(
  parameter int ROWS   = 5,
  parameter int COLS   = 5,
  parameter int ELEM_W = 8,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  mat_row_writer_if.slave   bus,
  output logic              busy,
  output logic              done,
  output logic              ovf_sticky
);

  localparam int RW    = COLS*ELEM_W;
  localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;

  typedef enum logic [1:0] {IDLE, WAIT_ROW, WRITE, FINISH} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] base_q;
  logic [ROW_W-1:0]  row_cnt;
  logic [COL_W-1:0]  col_cnt;
  logic [RW-1:0]     row_q;
  logic              sticky_q;
  logic              last_col, last_row;
  logic [ELEM_W-1:0] elem, elem_out;
  logic [ADDR_W-1:0] addr_calc;

  assign last_col = (col_cnt == COL_W'(COLS-1));
  assign last_row = (row_cnt == ROW_W'(ROWS-1));

  // The latched row shifts left on every accepted write, so the current element is always on top
  assign elem = row_q[RW-1 -: ELEM_W];

`ifdef MAT_WR_SAT_EN
  logic row_ovf_q;
  assign elem_out = (row_ovf_q && elem == {1'b1, {(ELEM_W-1){1'b0}}})
                  ? {1'b0, {(ELEM_W-1){1'b1}}} : elem;
`else
  assign elem_out = elem;
`endif

  assign addr_calc = base_q + ADDR_W'(row_cnt) * ADDR_W'(COLS) + ADDR_W'(col_cnt);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      base_q   <= '0;
      row_cnt  <= '0;
      col_cnt  <= '0;
      row_q    <= '0;
      sticky_q <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (start) begin
            base_q   <= base_addr;
            row_cnt  <= '0;
            sticky_q <= 1'b0;
          end
        end
        WAIT_ROW: begin
          if (bus.in_valid) begin
            row_q    <= bus.in_row;
            sticky_q <= sticky_q | bus.in_ovf;
            col_cnt  <= '0;
          end
        end
        WRITE: begin
          if (bus.mem_ready) begin
            row_q <= row_q << ELEM_W;
            if (last_col) begin
              col_cnt <= '0;
              row_cnt <= last_row ? '0 : row_cnt + 1'b1;
            end else begin
              col_cnt <= col_cnt + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

`ifdef MAT_WR_SAT_EN
  always_ff @(posedge clk) begin
    if (rst)
      row_ovf_q <= 1'b0;
    else if (state == WAIT_ROW && bus.in_valid)
      row_ovf_q <= bus.in_ovf;
  end
`endif

  // Outputs are decoded from state only; address and data are forced to zero outside WRITE
  always_comb begin
    state_nxt       = state;
    busy            = 1'b1;
    done            = 1'b0;
    bus.in_ready    = 1'b0;
    bus.mem_wr_en   = 1'b0;
    bus.mem_addr    = '0;
    bus.mem_wr_data = '0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_nxt = WAIT_ROW;
      end
      WAIT_ROW: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) state_nxt = WRITE;
      end
      WRITE: begin
        bus.mem_wr_en   = 1'b1;
        bus.mem_addr    = addr_calc;
        bus.mem_wr_data = elem_out;
        if (bus.mem_ready && last_col)
          state_nxt = last_row ? FINISH : WAIT_ROW;
      end
      FINISH: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign ovf_sticky = sticky_q;

endmodule

// File: tb/tb_mat_row_writer.sv
// Directed self-checking bench for mat_row_writer (default ROWS=COLS=5, 8-bit data/address).
// Build with MAT_WR_SAT_EN defined to check the saturating variant.
module tb_mat_row_writer;

  localparam int ROWS   = 5;
  localparam int COLS   = 5;
  localparam int ELEM_W = 8;
  localparam int ADDR_W = 8;
  localparam int RW     = COLS*ELEM_W;
  localparam int NWR    = ROWS*COLS;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] base_addr = 8'h00;
  logic       busy, done, ovf_sticky;

  mat_row_writer_if #(.COLS(COLS), .ELEM_W(ELEM_W), .ADDR_W(ADDR_W)) bus ();

  mat_row_writer #(.ROWS(ROWS), .COLS(COLS), .ELEM_W(ELEM_W), .ADDR_W(ADDR_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .base_addr (base_addr),
    .bus       (bus.slave),
    .busy      (busy),
    .done      (done),
    .ovf_sticky(ovf_sticky)
  );

  always #5 clk = ~clk;

  logic [RW-1:0] row_tab [ROWS];
  logic          ovf_tab [ROWS];
  logic [7:0]    exp_addr [NWR];
  logic [7:0]    exp_data [NWR];
  logic [7:0]    log_addr [32];
  logic [7:0]    log_data [32];
  int  wr_cnt = 0, sent = 0, done_cnt = 0, seq_err = 0, rdy_err = 0, stall_ctr = 0;
  int  cyc = 0, start_cyc = 0, done_cyc = 0, run_id = 0, seen_run = 0;
  bit  bp_mode = 1'b0, gap_mode = 1'b0;
  int  tests_run = 0, tests_failed = 0;

  // Row producer and memory model drive at the falling edge; the monitor samples 1 ns later,
  // seeing exactly what the next rising edge will see.
  always @(negedge clk) begin
    bus.in_valid = (sent < ROWS) && (!gap_mode || (cyc % 3 != 0));
    bus.in_row   = (sent < ROWS) ? row_tab[sent] : '0;
    bus.in_ovf   = (sent < ROWS) ? ovf_tab[sent] : 1'b0;
    if (bp_mode && bus.mem_wr_en && (wr_cnt % 2 == 1) && stall_ctr < 3) begin
      bus.mem_ready = 1'b0;
      stall_ctr++;
    end else begin
      bus.mem_ready = 1'b1;
    end
    #1;
    cyc++;
    if (seen_run != run_id) begin
      seen_run  = run_id;
      wr_cnt    = 0;
      sent      = 0;
      done_cnt  = 0;
      seq_err   = 0;
      rdy_err   = 0;
      stall_ctr = 0;
    end
    if (!rst) begin
      if (start && !busy) start_cyc = cyc;
      if (bus.mem_wr_en) begin
        if (wr_cnt >= NWR || bus.mem_addr !== exp_addr[wr_cnt] || bus.mem_wr_data !== exp_data[wr_cnt])
          seq_err++;
        if (bus.in_ready !== 1'b0) rdy_err++;
        if (bus.mem_ready) begin
          if (wr_cnt < 32) begin
            log_addr[wr_cnt] = bus.mem_addr;
            log_data[wr_cnt] = bus.mem_wr_data;
          end
          wr_cnt++;
          stall_ctr = 0;
        end
      end
      if (bus.in_valid && bus.in_ready) sent++;
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests_run++;
    assert (observed === expected)
    else begin
      tests_failed++;
      $error("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Builds the expected write sequence from the row table, then pulses start for one cycle
  task automatic applyStimulus(input logic [7:0] base);
    logic [RW-1:0] rv;
    logic [7:0]    e;
    @(negedge clk);
    for (int r = 0; r < ROWS; r++) begin
      rv = row_tab[r];
      for (int c = 0; c < COLS; c++) begin
        e = rv[RW-1-c*8 -: 8];
`ifdef MAT_WR_SAT_EN
        if (ovf_tab[r] && e == 8'h80) e = 8'h7F;
`endif
        exp_addr[r*COLS+c] = base + 8'(r*COLS+c);
        exp_data[r*COLS+c] = e;
      end
    end
    run_id++;
    start     = 1'b1;
    base_addr = base;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic waitDone(input string tag, input int max_cycles);
    for (int i = 0; i < max_cycles; i++) begin
      @(negedge clk);
      if (done_cnt > 0) break;
    end
    repeat (3) @(negedge clk);
    checkOutput(tag, done_cnt, 1);
  endtask

  task automatic waitWrites(input string tag, input int n);
    for (int i = 0; i < 300; i++) begin
      if (wr_cnt >= n) break;
      @(negedge clk);
    end
    checkOutput(tag, 32'(wr_cnt >= n), 1);
  endtask

  initial begin
    for (int r = 0; r < ROWS; r++) begin
      row_tab[r] = 40'h0102030405;
      ovf_tab[r] = 1'b0;
    end
    repeat (2) @(negedge clk);
    checkOutput("reset busy", busy, 0);
    checkOutput("reset done", done, 0);
    checkOutput("reset ovf_sticky", ovf_sticky, 0);
    checkOutput("reset in_ready", bus.in_ready, 0);
    checkOutput("reset mem_wr_en", bus.mem_wr_en, 0);
    checkOutput("reset mem_addr", bus.mem_addr, 0);
    checkOutput("reset mem_wr_data", bus.mem_wr_data, 0);
    rst = 1'b0;

    // Plain store at base 0x10
    applyStimulus(8'h10);
    waitDone("t1 done pulses once", 200);
    checkOutput("t1 done latency", done_cyc - start_cyc, 31);
    checkOutput("t1 write count", wr_cnt, 25);
    checkOutput("t1 sequence errors", seq_err, 0);
    checkOutput("t1 in_ready during write", rdy_err, 0);
    checkOutput("t1 first addr", log_addr[0], 8'h10);
    checkOutput("t1 last addr", log_addr[24], 8'h28);
    checkOutput("t1 data col3", log_data[3], 8'h04);
    checkOutput("t1 data row4 col4", log_data[24], 8'h05);
    checkOutput("t1 ovf_sticky", ovf_sticky, 0);
    checkOutput("t1 busy after done", busy, 0);

    // Overflowed row 2 containing the most negative element
    row_tab[2] = 40'h807F00FF01;
    ovf_tab[2] = 1'b1;
    applyStimulus(8'h10);
    waitWrites("t2 reach row1", 5);
    checkOutput("t2 ovf_sticky before row2", ovf_sticky, 0);
    waitWrites("t2 reach row2", 11);
    checkOutput("t2 ovf_sticky after row2", ovf_sticky, 1);
    waitDone("t2 done pulses once", 200);
    checkOutput("t2 addr 0x1A slot", log_addr[10], 8'h1A);
`ifdef MAT_WR_SAT_EN
    checkOutput("t2 data at 0x1A", log_data[10], 8'h7F);
`else
    checkOutput("t2 data at 0x1A", log_data[10], 8'h80);
`endif
    checkOutput("t2 data at 0x1B", log_data[11], 8'h7F);
    checkOutput("t2 data at 0x1D", log_data[13], 8'hFF);
    checkOutput("t2 sequence errors", seq_err, 0);
    checkOutput("t2 ovf_sticky held", ovf_sticky, 1);

    // Address wrap from base 0xF0
    row_tab[2] = 40'h0102030405;
    ovf_tab[2] = 1'b0;
    applyStimulus(8'hF0);
    waitDone("t3 done pulses once", 200);
    checkOutput("t3 addr before wrap", log_addr[15], 8'hFF);
    checkOutput("t3 addr 17th write", log_addr[16], 8'h00);
    checkOutput("t3 final addr", log_addr[24], 8'h08);
    checkOutput("t3 sequence errors", seq_err, 0);
    checkOutput("t3 ovf_sticky cleared", ovf_sticky, 0);

    // Memory backpressure and gapped row valid
    row_tab[0] = 40'h1112131415;
    row_tab[1] = 40'h2122232425;
    row_tab[2] = 40'h3132333435;
    row_tab[3] = 40'h4142434445;
    row_tab[4] = 40'h5152535455;
    bp_mode  = 1'b1;
    gap_mode = 1'b1;
    applyStimulus(8'h40);
    waitDone("t4 done pulses once", 400);
    checkOutput("t4 write count", wr_cnt, 25);
    checkOutput("t4 sequence errors", seq_err, 0);
    checkOutput("t4 in_ready during write", rdy_err, 0);
    checkOutput("t4 data row1 col2", log_data[7], 8'h23);
    checkOutput("t4 last addr", log_addr[24], 8'h58);
    checkOutput("t4 stalls lengthen store", 32'((done_cyc - start_cyc) >= 67), 1);
    bp_mode  = 1'b0;
    gap_mode = 1'b0;

    // Reset while row 3 col 2 is presented
    for (int r = 0; r < ROWS; r++) row_tab[r] = 40'h0102030405;
    ovf_tab[1] = 1'b1;
    applyStimulus(8'h10);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (wr_cnt == 17 && bus.mem_wr_en) begin
        rst = 1'b1;
        break;
      end
    end
    checkOutput("t5 reached row3 col2", wr_cnt, 17);
    @(negedge clk);
    checkOutput("t5 abort mem_wr_en", bus.mem_wr_en, 0);
    checkOutput("t5 abort mem_addr", bus.mem_addr, 0);
    checkOutput("t5 abort mem_wr_data", bus.mem_wr_data, 0);
    checkOutput("t5 abort busy", busy, 0);
    checkOutput("t5 abort in_ready", bus.in_ready, 0);
    checkOutput("t5 abort ovf_sticky", ovf_sticky, 0);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    checkOutput("t5 no writes after abort", wr_cnt, 17);
    checkOutput("t5 no done after abort", done_cnt, 0);
    ovf_tab[1] = 1'b0;
    applyStimulus(8'h20);
    waitDone("t5 restart done", 200);
    checkOutput("t5 restart write count", wr_cnt, 25);
    checkOutput("t5 restart first addr", log_addr[0], 8'h20);
    checkOutput("t5 restart sequence errors", seq_err, 0);
    checkOutput("t5 restart latency", done_cyc - start_cyc, 31);

    // start pulsed mid-store with a different base must be ignored
    applyStimulus(8'h10);
    waitWrites("t6 reach write 8", 8);
    start     = 1'b1;
    base_addr = 8'h77;
    @(negedge clk);
    start = 1'b0;
    waitDone("t6 done pulses once", 200);
    checkOutput("t6 sequence errors", seq_err, 0);
    checkOutput("t6 last addr", log_addr[24], 8'h28);
    checkOutput("t6 latency", done_cyc - start_cyc, 31);
    checkOutput("t6 write count", wr_cnt, 25);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
